// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the mem_arbiter slice.
//   arb_state_t : IDLE -> ACC -> DONE access sequencer states
//   PORT_A/B    : grant IDs carried through the access
//   OOR_RDATA   : value returned by an out-of-range read
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} arb_state_t;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  localparam logic [7:0] OOR_RDATA = 8'hFF;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational two-requester picker.
//   a_req_i, b_req_i : request levels
//   last_win_i       : previous winner (only with MEM_ARB_RR_EN)
//   gnt_vld_o        : some request is pending
//   gnt_id_o         : winning port ID
// MEM_ARB_RR_EN defined: ties go to the port that did not win last;
// otherwise port A always wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic a_req_i,
  input  logic b_req_i,
`ifdef MEM_ARB_RR_EN
  input  logic last_win_i,
`endif
  output logic gnt_vld_o,
  output logic gnt_id_o
);
  assign gnt_vld_o = a_req_i | b_req_i;
`ifdef MEM_ARB_RR_EN
  assign gnt_id_o = (a_req_i & b_req_i) ? ~last_win_i : (a_req_i ? PORT_A : PORT_B);
`else
  assign gnt_id_o = a_req_i ? PORT_A : PORT_B;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory CPU-side port between requester A (CPU) and B (DMA).
//   clk, reset_n           : clock, async active-low reset
//   a_*/b_* req/we/addr/wdata : requests, held until the matching ack
//   a_ack/b_ack, a_rdata/b_rdata : one-cycle completion pulse and registered read data
//   mem_*                  : memory write/output enables, address, write data, read data
//   busy, range_err        : access in flight; sticky out-of-range flag
// Optional round-robin tie breaking is enabled by defining MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int SIZE   = 8192,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wdata,
  output logic              a_ack,
  output logic [7:0]        a_rdata,
  output logic              b_ack,
  output logic [7:0]        b_rdata,
  output logic              mem_write_enable,
  output logic              mem_output_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_data_in,
  input  logic [7:0]        mem_data_out,
  output logic              busy,
  output logic              range_err
);
  localparam logic [ADDR_W:0] SIZE_L = (ADDR_W+1)'(SIZE);
  arb_state_t state_q, state_d;
  logic we_q, we_d, id_q, id_d, oor_q, oor_d, range_err_q, range_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic gnt_vld, gnt_id;
`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
`endif
  mem_arb_pick u_pick (
    .a_req_i    (a_req),
    .b_req_i    (b_req),
`ifdef MEM_ARB_RR_EN
    .last_win_i (last_q),
`endif
    .gnt_vld_o  (gnt_vld),
    .gnt_id_o   (gnt_id)
  );
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata, rd_val;
  assign req_we    = (gnt_id == PORT_B) ? b_we : a_we;
  assign req_addr  = (gnt_id == PORT_B) ? b_addr : a_addr;
  assign req_wdata = (gnt_id == PORT_B) ? b_wdata : a_wdata;
  assign rd_val    = oor_q ? OOR_RDATA : mem_data_out;
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    id_d        = id_q;
    oor_d       = oor_q;
    range_err_d = range_err_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif
    if (state_q == IDLE && gnt_vld) begin
      state_d     = ACC;
      we_d        = req_we;
      addr_d      = req_addr;
      wdata_d     = req_wdata;
      id_d        = gnt_id;
      oor_d       = {1'b0, req_addr} >= SIZE_L;
      range_err_d = range_err_q | oor_d;
`ifdef MEM_ARB_RR_EN
      last_d      = gnt_id;
`endif
    end else if (state_q == ACC) begin
      state_d   = DONE;
      a_rdata_d = (!we_q && id_q == PORT_A) ? rd_val : a_rdata_q;
      b_rdata_d = (!we_q && id_q == PORT_B) ? rd_val : b_rdata_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      id_q        <= PORT_A;
      oor_q       <= 1'b0;
      range_err_q <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
      last_q      <= PORT_B;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      id_q        <= id_d;
      oor_q       <= oor_d;
      range_err_q <= range_err_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end
  // Enables decode from registered state only, so reset drops them at once and
  // an interrupted write never reaches the memory's falling-edge commit.
  assign mem_write_enable  = (state_q == ACC) & we_q & ~oor_q;
  assign mem_output_enable = (state_q == ACC) & ~we_q & ~oor_q;
  assign mem_address       = addr_q;
  assign mem_data_in       = wdata_q;
  assign a_ack             = (state_q == DONE) & (id_q == PORT_A);
  assign b_ack             = (state_q == DONE) & (id_q == PORT_B);
  assign a_rdata           = a_rdata_q;
  assign b_rdata           = b_rdata_q;
  assign busy              = state_q != IDLE;
  assign range_err         = range_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural memory.
module tb_mem_arbiter;
  logic clk = 1'b0, reset_n = 1'b0;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [14:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;
  logic a_ack, b_ack, mem_write_enable, mem_output_enable, busy, range_err;
  logic [7:0] a_rdata, b_rdata, mem_data_in, mem_data_out;
  logic [14:0] mem_address;
  int checks = 0, failures = 0;
  int oe_cnt = 0, we_cnt = 0, aack_cnt = 0, back_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.SIZE(8192), .ADDR_W(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_write_enable(mem_write_enable), .mem_output_enable(mem_output_enable),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .busy(busy), .range_err(range_err)
  );

  function automatic logic [7:0] pat(input int i);
    if (i == 'h0100) return 8'h5A;
    if (i == 'h1FFF) return 8'hE7;
    return 8'(i * 7 + 3);
  endfunction

  // memory: commits writes on the falling edge, combinational read when enabled
  logic [7:0] mem [0:8191];
  logic loaded = 1'b0;
  always @(negedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 8192; i++) mem[i] <= pat(i);
      loaded <= 1'b1;
    end else if (mem_write_enable) mem[mem_address[12:0]] <= mem_data_in;
    oe_cnt   <= oe_cnt + int'(mem_output_enable);
    we_cnt   <= we_cnt + int'(mem_write_enable);
    aack_cnt <= aack_cnt + int'(a_ack);
    back_cnt <= back_cnt + int'(b_ack);
  end
  assign mem_data_out = mem_output_enable ? mem[mem_address[12:0]] : 8'h00;

  // reference model state
  logic [7:0] ref_mem [0:8191];
  logic [7:0] rd_model [2];
  logic rerr_model;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one transaction on one port; returns edges from drive to ack (2 when idle)
  task automatic xact(input logic port, input logic we, input logic [14:0] addr,
                      input logic [7:0] wd, output logic [7:0] rd, output int lat, output logic got);
    if (port) begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1; end
    else begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1; end
    lat = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      lat++;
      got = port ? b_ack : a_ack;
    end
    rd = port ? b_rdata : a_rdata;
    a_req = 0;
    b_req = 0;
    tick();
  endtask

  // model-driven transaction: computes expectations from the address map rules
  task automatic model_xact(input string nm, input logic port, input logic we,
                            input logic [14:0] addr, input logic [7:0] wd);
    logic [7:0] rd;
    int lat, oe0, we0, ao0, bo0;
    logic got, oor;
    oor = addr >= 15'd8192;
    oe0 = oe_cnt; we0 = we_cnt; ao0 = aack_cnt; bo0 = back_cnt;
    xact(port, we, addr, wd, rd, lat, got);
    if (oor) rerr_model = 1'b1;
    if (we && !oor) ref_mem[addr[12:0]] = wd;
    if (!we) rd_model[port] = oor ? 8'hFF : ref_mem[addr[12:0]];
    chk({nm, ".ack"}, got, 1);
    chk({nm, ".lat"}, lat, 2);
    chk({nm, ".rdata"}, rd, rd_model[port]);
    chk({nm, ".rerr"}, range_err, rerr_model);
    chk({nm, ".oe_pulses"}, oe_cnt - oe0, (!we && !oor) ? 1 : 0);
    chk({nm, ".we_pulses"}, we_cnt - we0, (we && !oor) ? 1 : 0);
    chk({nm, ".ack_own"}, port ? back_cnt - bo0 : aack_cnt - ao0, 1);
    chk({nm, ".ack_other"}, port ? aack_cnt - ao0 : back_cnt - bo0, 0);
    if (we && !oor) chk({nm, ".mem"}, mem[addr[12:0]], wd);
  endtask

  // simultaneous reads on both ports; returns ack cycle numbers
  task automatic tie(input logic [14:0] aa, input logic [14:0] ba, output int ta, output int tb);
    a_we = 0; b_we = 0; a_addr = aa; b_addr = ba; a_req = 1; b_req = 1;
    ta = -1; tb = -1;
    for (int n = 1; n < 20 && (ta < 0 || tb < 0); n++) begin
      tick();
      if (a_ack) begin ta = n; a_req = 0; end
      if (b_ack) begin tb = n; b_req = 0; end
    end
    a_req = 0; b_req = 0;
    tick();
    rd_model[0] = ref_mem[aa[12:0]];
    rd_model[1] = ref_mem[ba[12:0]];
    chk("tie.a_rdata", a_rdata, rd_model[0]);
    chk("tie.b_rdata", b_rdata, rd_model[1]);
  endtask

  typedef struct {
    logic port; logic we; logic [14:0] addr; logic [7:0] wdata; logic [7:0] exp_rd; logic exp_re;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int ta, tb, lat, b0;
    logic [7:0] rd;
    logic got;
    for (int i = 0; i < 8192; i++) ref_mem[i] = pat(i);
    rd_model[0] = 0; rd_model[1] = 0; rerr_model = 0;
    tbl[0] = '{0, 0, 15'h0100, 8'h00, 8'h5A, 0};
    tbl[1] = '{1, 1, 15'h1FFC, 8'hC3, 8'h00, 0};
    tbl[2] = '{1, 0, 15'h1FFC, 8'h00, 8'hC3, 0};
    tbl[3] = '{0, 1, 15'h0005, 8'h11, 8'h5A, 0};
    tbl[4] = '{1, 0, 15'h0005, 8'h00, 8'h11, 0};
    tbl[5] = '{0, 1, 15'h2000, 8'h77, 8'h5A, 1};
    tbl[6] = '{0, 0, 15'h2000, 8'h00, 8'hFF, 1};
    tbl[7] = '{1, 0, 15'h1FFF, 8'h00, 8'hE7, 1};
    repeat (3) @(posedge clk);
    #2;
    chk("rst.busy", busy, 0);
    chk("rst.ack", {a_ack, b_ack}, 0);
    chk("rst.en", {mem_write_enable, mem_output_enable}, 0);
    chk("rst.addr", mem_address, 0);
    chk("rst.rdata", {a_rdata, b_rdata}, 0);
    chk("rst.rerr", range_err, 0);
    reset_n = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      model_xact($sformatf("vec%0d", i), tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("vec%0d.tbl_rdata", i), tbl[i].port ? b_rdata : a_rdata, tbl[i].exp_rd);
      chk($sformatf("vec%0d.tbl_rerr", i), range_err, tbl[i].exp_re);
    end
    // B wins alone, so the following tie goes to A in both modes
    model_xact("pre_tie1", 1, 0, 15'h0100, 0);
    tie(15'h0005, 15'h1FFC, ta, tb);
    chk("tie1.a_first", tb - ta, 3);
    // A wins alone; round-robin now favours B on the next tie
    model_xact("pre_tie2", 0, 0, 15'h1FFF, 0);
    tie(15'h0100, 15'h0005, ta, tb);
`ifdef MEM_ARB_RR_EN
    chk("tie2.b_first", ta - tb, 3);
`else
    chk("tie2.a_first", tb - ta, 3);
`endif
    for (int i = 0; i < 60; i++) begin
      int sel;
      logic [14:0] base;
      sel = $urandom_range(0, 2);
      base = sel == 0 ? 15'h0000 : (sel == 1 ? 15'h1FF0 : 15'h2000);
      model_xact($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 base + 15'($urandom_range(0, 15)), 8'($urandom));
    end
    // reset during the ACC cycle of a B write
    b0 = back_cnt;
    b_we = 1; b_addr = 15'h0010; b_wdata = ~ref_mem['h10]; b_req = 1;
    tick();
    chk("rmid.in_acc", mem_write_enable, 1);
    reset_n = 0;
    #1;
    rd_model[0] = 0; rd_model[1] = 0; rerr_model = 0;
    chk("rmid.busy", busy, 0);
    chk("rmid.en", {mem_write_enable, mem_output_enable}, 0);
    chk("rmid.ack", {a_ack, b_ack}, 0);
    chk("rmid.addr", mem_address, 0);
    chk("rmid.rdata", {a_rdata, b_rdata}, 0);
    chk("rmid.rerr", range_err, 0);
    b_req = 0;
    a_we = 0; a_addr = 15'h0100; a_req = 1;
    tick();
    reset_n = 1;
    chk("rmid.mem", mem['h10], ref_mem['h10]);
    got = 0;
    lat = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      lat++;
      got = a_ack;
    end
    a_req = 0;
    tick();
    chk("rmid.a_ack", got, 1);
    chk("rmid.a_lat", lat, 2);
    chk("rmid.a_rdata", a_rdata, ref_mem['h100]);
    chk("rmid.no_b_ack", back_cnt - b0, 0);
    begin
      int bad = 0;
      for (int i = 0; i < 8192; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk("final.mem_diffs", bad, 0);
    end
    rd = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single CPU-side port of the 8-bit `rom_or_ram` memory between a CPU requester (port A) and a DMA/loader requester (port B). It serialises requests into one-cycle memory accesses, drives the memory's write/output enables, registers read data back to the winner and returns a one-cycle acknowledge. It sits between the 6502 bus glue and the memory instance; the memory's Q1 (video) port stays outside it.

## Interface
Parameters:
- `SIZE`, 8192: number of memory bytes; addresses `>= SIZE` are out of range.
- `ADDR_W`, 15: address width on all ports.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_req`, `b_req`  in  1  request level, held until `*_ack`.
- `a_we`, `b_we`  in  1  1 = write, 0 = read; stable while `*_req`.
- `a_addr`, `b_addr`  in  ADDR_W  byte address; stable while `*_req`.
- `a_wdata`, `b_wdata`  in  8  write data; stable while `*_req`.
- `a_ack`, `b_ack`  out  1  one-cycle completion pulse.
- `a_rdata`, `b_rdata`  out  8  read result, valid from `*_ack` until the next completion on that port.
- `mem_write_enable`  out  1  to memory `write_enable`.
- `mem_output_enable`  out  1  to memory `output_enable`.
- `mem_address`  out  ADDR_W  to memory `ADDRESS`.
- `mem_data_in`  out  8  to memory `DATA_IN`.
- `mem_data_out`  in  8  from memory `DATA_OUT`.
- `busy`  out  1  high in ACC and DONE.
- `range_err`  out  1  sticky; set by any out-of-range request, cleared only by reset.

## Operation
- States: IDLE, ACC, DONE.
- IDLE: at each rising edge, if any `*_req` is high, pick a winner and latch its `we`/`addr`/`wdata` plus port ID; go to ACC. Otherwise stay.
- Arbitration: with one request pending, that port wins. With both pending, see Configuration.
- ACC (exactly one cycle):
  - `mem_address` = latched address.
  - `mem_output_enable` = 1 for a read.
  - `mem_write_enable` = 1 for a write, so the memory commits on the falling edge mid-cycle.
  - `mem_data_in` = latched data.
  - At the end of ACC: reads capture `mem_data_out` into the winner's `rdata`; writes leave `rdata` unchanged. Go to DONE.
- DONE (one cycle): winner's `ack` = 1; all mem enables 0; go to IDLE. The requester lowers `req` or presents a new request at the edge ending DONE. `req` is not sampled in DONE.
- Out of range (`addr >= SIZE`):
  - ACC drives both enables 0.
  - A read returns 8'hFF; a write is discarded.
  - `ack` is still given, and `range_err` is set.
- Outside ACC, `mem_address` and `mem_data_in` hold their last values and both enables are 0.
- `reset_n` low at any time, including mid-ACC, forces:
  - state IDLE;
  - all `ack`, enables, `busy` and `range_err` to 0;
  - `rdata` to 8'h00 and `mem_address` to 0;
  - last-winner to B.
- A write interrupted by reset before the falling edge is not performed.

## Timing
- Request seen at rising edge N (IDLE): ACC in cycle N..N+1, `ack` high in cycle N+1..N+2, state IDLE from N+2.
- Latency is 2 cycles from the sampling edge to `ack`. Peak throughput is one access per 3 cycles.
- `rdata` updates at the same edge that raises `ack`.
- All outputs are registered or decoded from registered state only; there are no combinational paths from request inputs to memory outputs.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On simultaneous requests, the port that did not win last wins. Last-winner updates on every grant and resets to B, so A wins the first tie.
- Not defined: fixed priority. A always wins ties, and B can starve under continuous A traffic. Last-winner register is absent.

## Structure
- Package `mem_arb_pkg`:
  - state enum `arb_state_t` (IDLE, ACC, DONE);
  - port ID constants `PORT_A` = 0, `PORT_B` = 1;
  - read-fill constant `OOR_RDATA` = 8'hFF.
- One sub-module `mem_arb_pick`: combinational two-input picker. Inputs: `a_req`, `b_req`, last-winner. Outputs: grant valid, grant ID. Round-robin versus fixed-priority logic is selected inside it by `MEM_ARB_RR_EN`.

## Test plan
- Single read: preload memory[16'h0100] = 8'h5A; A reads 15'h0100. Required: `mem_output_enable` high for exactly 1 cycle, `a_ack` 2 cycles after the sampling edge, `a_rdata` = 8'h5A, `b_ack` never high.
- Write then read: B writes 8'hC3 to 15'h1FFC, then reads it back. Required: memory[15'h1FFC] = 8'hC3 after the write's ACC cycle; `b_rdata` = 8'hC3.
- Tie: A and B both request reads at the same edge. Required: A is served first; B is acked exactly 3 cycles after A. With `MEM_ARB_RR_EN`, a second simultaneous pair is served B first.
- Out of range, SIZE = 8192: A writes 8'h77 to 15'h2000. Required: no `mem_write_enable` pulse; `a_ack` given; `range_err` = 1 and stays 1. A following read of 15'h2000 returns 8'hFF.
- Reset mid-operation: assert `reset_n` = 0 during the ACC cycle of a B write. Required: memory unchanged, no `b_ack`, all outputs at reset values. After release, a pending A request completes normally.
